logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's basic AND/OR/NOT gate block.
- Performs one of eight bitwise operations on WIDTH-bit operands, with a valid/ready handshake on both sides.
- Has an accumulate mode that folds a burst of operands into one result.
- Sits between a register-file/operand source and a result sink in lab datapaths.

---
 rtl/logic_unit_pkg.sv | 32 +++
 rtl/logic_unit_core.sv | 20 ++
 rtl/logic_unit_pipe.sv | 132 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encoding and the per-bit operation used by logic_unit_core.
// Optional result flags are enabled by defining LOGIC_UNIT_FLAGS_EN.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOT  = 3'd2;
  localparam op_t OP_XOR  = 3'd3;
  localparam op_t OP_NAND = 3'd4;
  localparam op_t OP_NOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  // Every op is bitwise, so the width is set by how many bits the caller feeds in.
  function automatic logic op_bit(input op_t op, input logic x, input logic y);
    logic r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOT:  r = ~x;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational bitwise F(op, x, y) over WIDTH bits.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] r_o
);

  always_comb begin
    r_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r_o[i] = op_bit(op_i, x_i[i], y_i[i]);
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with accumulate bursts and valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to add registered oZero/oParity result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [2:0]       iOp,
  input  logic             iAccum,
  input  logic             iLast,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             oZero,
  output logic             oParity
`endif
);

  // Handshake: a beat moves on a side when its valid and ready are both high in
  // the same cycle; valid holds with stable data until then. oReady is
  // combinational from iReady (no skid buffer).

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  op_t              s1_op_q;
  logic             s1_accum_q, s1_last_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_active_q, acc_active_d;

  logic             accept, adv, load, chain;
  logic [WIDTH-1:0] core_x, core_y, core_r;

  assign adv    = s1_valid_q && (!s2_valid_q || iReady);
  assign oReady = !s1_valid_q || adv;
  assign accept = iValid && oReady;
  // Later burst beats fold into the accumulator: F(acc, A), B unused.
  assign chain  = s1_accum_q && acc_active_q;
  assign core_x = chain ? acc_q : s1_a_q;
  assign core_y = chain ? s1_a_q : s1_b_q;
  assign load   = adv && (!s1_accum_q || s1_last_q);

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i (s1_op_q),
    .x_i  (core_x),
    .y_i  (core_y),
    .r_o  (core_r)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s2_valid_d   = s2_valid_q;
    result_d     = result_q;
    acc_d        = acc_q;
    acc_active_d = acc_active_q;
    if (adv)    s1_valid_d = 1'b0;
    if (accept) s1_valid_d = 1'b1;
    if (iReady) s2_valid_d = 1'b0;
    if (load) begin
      s2_valid_d = 1'b1;
      result_d   = core_r;
    end
    if (adv) begin
      // Anything other than a non-final burst beat ends (or aborts) the burst.
      if (s1_accum_q && !s1_last_q) begin
        acc_d        = core_r;
        acc_active_d = 1'b1;
      end else begin
        acc_d        = '0;
        acc_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= OP_AND;
      s1_accum_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      acc_q        <= '0;
      acc_active_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      result_q     <= result_d;
      acc_q        <= acc_d;
      acc_active_q <= acc_active_d;
      if (accept) begin
        s1_a_q     <= iA;
        s1_b_q     <= iB;
        s1_op_q    <= iOp;
        s1_accum_q <= iAccum;
        s1_last_q  <= iLast;
      end
    end
  end

  assign oValid  = s2_valid_q;
  assign oResult = result_q;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q, parity_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (load) begin
      zero_q   <= (core_r == '0);
      parity_q <= ^core_r;
    end
  end

  assign oZero   = zero_q;
  assign oParity = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus random traffic against a burst-level model.
module tb_logic_unit_pipe;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst_n;
  always #5 iClk = ~iClk;

  logic         iValid, oReady, iAccum, iLast, oValid, iReady;
  logic [W-1:0] iA, iB, oResult;
  logic [2:0]   iOp;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic oZero, oParity;
`endif

  logic_unit_pipe #(.WIDTH(W)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iValid  (iValid),
    .oReady  (oReady),
    .iA      (iA),
    .iB      (iB),
    .iOp     (iOp),
    .iAccum  (iAccum),
    .iLast   (iLast),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .oZero   (oZero),
    .oParity (oParity)
`endif
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] lit_q[$];
  int           lat_q[$];
  bit           lat_on = 0;
  bit           rnd_rdy = 0;
  bit           acc_seen = 0;
  int           cyc = 0;
  int           n_acc = 0;
  logic         m_act = 1'b0;
  logic [W-1:0] m_acc = '0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_r = '0;
  logic [W-1:0] m_r, e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Spec-level meaning of each op.
  function automatic logic [W-1:0] f(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~x;
      3'd3: return x ^ y;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // ---------------- monitor + scoreboard ----------------
  always @(negedge iClk) begin
    if (iRst_n) begin
      cyc++;
      if (hold_v) begin
        check("hold_valid", oValid, 1);
        check("hold_result", oResult, hold_r);
      end
      hold_v = oValid && !iReady;
      hold_r = oResult;
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", oValid, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", oResult, e);
`ifdef LOGIC_UNIT_FLAGS_EN
          check("zero_flag", oZero, (e == '0));
          check("parity_flag", oParity, ^e);
`endif
          if (lit_q.size() > 0) check("literal", oResult, lit_q.pop_front());
          if (lat_on && lat_q.size() > 0) check("latency", cyc, lat_q.pop_front());
        end
      end
      acc_seen = iValid && oReady;
      if (acc_seen) begin
        n_acc++;
        if (!iAccum) begin
          exp_q.push_back(f(iOp, iA, iB));
          if (lat_on) lat_q.push_back(cyc + 2);
          m_act = 1'b0;
        end else begin
          m_r = m_act ? f(iOp, m_acc, iA) : f(iOp, iA, iB);
          if (iLast) begin
            exp_q.push_back(m_r);
            if (lat_on) lat_q.push_back(cyc + 2);
            m_act = 1'b0;
          end else begin
            m_acc = m_r;
            m_act = 1'b1;
          end
        end
      end
    end else begin
      acc_seen = 1'b0;
    end
  end

  // Random sink backpressure when enabled.
  initial begin
    forever begin
      @(posedge iClk);
      #1;
      if (rnd_rdy) iReady = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic accum, input logic last);
    int n = 0;
    iValid = 1'b1; iA = a; iB = b; iOp = op; iAccum = accum; iLast = last;
    @(negedge iClk); #1;
    while (!acc_seen && n < 50) begin
      @(negedge iClk); #1;
      n++;
    end
    if (n >= 50) check("send_timeout", oReady, 1);
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(posedge iClk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge iClk);
    #1;
  endtask

  task automatic async_reset();
    @(posedge iClk);
    #3 iRst_n = 1'b0;
    #1;
    check("arst_ovalid", oValid, 0);
    check("arst_oready", oReady, 1);
    check("arst_result", oResult, 0);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("arst_zero", oZero, 0);
    check("arst_parity", oParity, 0);
`endif
    exp_q.delete();
    lit_q.delete();
    lat_q.delete();
    m_act = 1'b0;
    hold_v = 1'b0;
    @(posedge iClk);
    #1 iRst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0;
    iRst_n = 1'b0; iValid = 1'b1; iReady = 1'b1;
    iA = 8'hAA; iB = 8'h55; iOp = 3'd0; iAccum = 1'b0; iLast = 1'b0;

    // Reset holds outputs quiet even with iValid high.
    @(negedge iClk);
    check("rst_ovalid", oValid, 0);
    check("rst_result", oResult, 0);
    check("rst_oready", oReady, 1);
    @(posedge iClk); #1;
    iRst_n = 1'b1; iValid = 1'b0;
    repeat (3) @(negedge iClk);
    check("post_rst_ovalid", oValid, 0);
    @(posedge iClk); #1;

    // All ops back to back, fixed latency.
    lat_on = 1;
    lit_q = '{8'h42, 8'hDB, 8'h3C, 8'h99, 8'hBD, 8'h24, 8'h66, 8'hC3};
    for (int op = 0; op < 8; op++) send(8'hC3, 8'h5A, 3'(op), 1'b0, 1'b0);
`ifdef LOGIC_UNIT_FLAGS_EN
    lit_q.push_back(8'h00);
    send(8'hFF, 8'h00, 3'd2, 1'b0, 1'b0);
`endif
    drain();
    lat_on = 0;
    lat_q.delete();

    // Accumulate XOR burst folds to one result.
    lit_q.push_back(8'h0F);
    send(8'h01, 8'h02, 3'd3, 1'b1, 1'b0);
    send(8'h04, 8'hEE, 3'd3, 1'b1, 1'b0);
    send(8'h08, 8'h77, 3'd3, 1'b1, 1'b1);
    drain();

    // Aborted burst, then a fresh burst reseeds.
    lit_q.push_back(8'h3F);
    lit_q.push_back(8'h33);
    send(8'hF0, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'h0F, 8'h30, 3'd1, 1'b0, 1'b0);
    send(8'h11, 8'h22, 3'd3, 1'b1, 1'b1);
    drain();

    // Backpressure: only two beats fit while the sink stalls.
    lit_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    iReady = 1'b0;
    n0 = n_acc;
    fork
      begin
        send(8'h11, 8'h00, 3'd7, 1'b0, 1'b0);
        send(8'h22, 8'h00, 3'd7, 1'b0, 1'b0);
        send(8'h33, 8'h00, 3'd7, 1'b0, 1'b0);
        send(8'h44, 8'h00, 3'd7, 1'b0, 1'b0);
      end
    join_none
    repeat (5) @(posedge iClk);
    #2;
    check("bp_accepts", n_acc - n0, 2);
    check("bp_oready", oReady, 0);
    check("bp_ovalid", oValid, 1);
    iReady = 1'b1;
    wait fork;
    drain();

    // Async reset with both stages full.
    iReady = 1'b0;
    send(8'h01, 8'h00, 3'd7, 1'b0, 1'b0);
    send(8'h02, 8'h00, 3'd7, 1'b0, 1'b0);
    async_reset();
    iReady = 1'b1;
    repeat (3) @(negedge iClk);
    check("arst_no_output", oValid, 0);
    @(posedge iClk); #1;

    // Async reset with a partial accumulator; next single-beat burst must not see it.
    send(8'hAA, 8'h00, 3'd7, 1'b1, 1'b0);
    repeat (3) @(posedge iClk);
    #1;
    async_reset();
    lit_q.push_back(8'hFF);
    send(8'h0F, 8'hF0, 3'd3, 1'b1, 1'b1);
    drain();

    // Random traffic with random sink stalls.
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge iClk);
      #1;
    end
    // Close any open burst so nothing is left pending.
    send(8'h5A, 8'hA5, 3'd1, 1'b0, 1'b0);
    rnd_rdy = 0;
    @(posedge iClk); #1;
    iReady = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
